// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router packet-control FSM.
// The optional WAIT_TILL_EMPTY timeout is enabled by ROUTER_FSM_TIMEOUT_EN.
package router_pkg;

  localparam int NUM_PORTS      = 3;
  localparam int ADDR_W         = 2;
  localparam int TIMEOUT_CYCLES = 30;

  // First header address that does not map to a destination FIFO.
  localparam logic [ADDR_W-1:0] ADDR_INVALID = ADDR_W'(NUM_PORTS);

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR,
    WAIT_TILL_EMPTY
  } state_t;

  // True when the header address selects an existing destination FIFO.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return a < ADDR_INVALID;
  endfunction

endpackage

// File: rtl/router_wait_timer.sv
// Cycle counter for WAIT_TILL_EMPTY: counts while i_run, clears when i_run drops,
// flags o_expire on the LIMIT-th consecutive running cycle.
module router_wait_timer #(
  parameter int LIMIT = 30
) (
  input  logic i_clk,
  input  logic i_rst,   // async, active-low
  input  logic i_run,
  output logic o_expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  // Count running cycles, saturating at the limit; leaving the run window clears.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                          r_cnt <= '0;
    else if (!i_run)                     r_cnt <= '0;
    else if (r_cnt != CW'(LIMIT - 1))    r_cnt <= r_cnt + 1'b1;
  end

  assign o_expire = i_run && (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/router_fsm_ctrl.sv
// Packet-control FSM of the 1x3 router: header decode, header/payload/parity load
// sequencing, FIFO-full stall and busy-destination wait. Moore outputs only.
// Optional feature: define ROUTER_FSM_TIMEOUT_EN to bound WAIT_TILL_EMPTY and
// pulse o_drop_pkt when a packet is abandoned.
module router_fsm_ctrl
  import router_pkg::*;
#(
  parameter int NP = NUM_PORTS,
  parameter int AW = ADDR_W
) (
  input  logic          i_clk,
  input  logic          i_rst,          // async, active-low
  input  logic          i_pkt_valid,
  input  logic [AW-1:0] i_din,
  input  logic          i_fifo_full,
  input  logic [NP-1:0] i_fifo_empty,
  input  logic [NP-1:0] i_soft_reset,
  input  logic          i_parity_done,
  input  logic          i_low_pkt_valid,
  output logic          o_detect_addr,
  output logic          o_lfd_state,
  output logic          o_ld_state,
  output logic          o_laf_state,
  output logic          o_full_state,
  output logic          o_rst_int_reg,
  output logic          o_write_enb_reg,
  output logic          o_busy,
  output logic          o_drop_pkt
);

  state_t        r_state, w_next;
  logic [AW-1:0] r_addr;
  logic          w_din_ok;
  logic          w_srst_sel;
  logic          w_expire;
  logic          w_timeout;

  assign w_din_ok   = int'(i_din) < NP;
  assign w_srst_sel = i_soft_reset[r_addr];

`ifdef ROUTER_FSM_TIMEOUT_EN
  logic r_drop;

  router_wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_wait_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_run    (r_state == WAIT_TILL_EMPTY),
    .o_expire (w_expire)
  );

  // A soft reset or the destination draining on the limit cycle both win over the drop.
  assign w_timeout = w_expire && !i_fifo_empty[r_addr] && !w_srst_sel;

  // Drop strobe is registered so it stays a pure state-derived output.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_drop <= 1'b0;
    else        r_drop <= w_timeout;
  end

  assign o_drop_pkt = r_drop;
`else
  assign w_expire   = 1'b0;
  assign w_timeout  = w_expire;
  assign o_drop_pkt = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= DECODE_ADDRESS;
    else        r_state <= w_next;
  end

  // Latch the destination when a valid header is seen in DECODE_ADDRESS.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                                               r_addr <= '0;
    else if (r_state == DECODE_ADDRESS && i_pkt_valid && w_din_ok) r_addr <= i_din;
  end

  // Next-state logic; a soft reset of the selected FIFO overrides every transition.
  always_comb begin
    w_next = r_state;
    if (w_srst_sel) begin
      w_next = DECODE_ADDRESS;
    end else begin
      case (r_state)
        DECODE_ADDRESS:
          if (i_pkt_valid && w_din_ok)
            w_next = i_fifo_empty[i_din] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        LOAD_FIRST_DATA:    w_next = LOAD_DATA;
        LOAD_DATA:
          if (i_fifo_full)       w_next = FIFO_FULL_STATE;
          else if (!i_pkt_valid) w_next = LOAD_PARITY;
        FIFO_FULL_STATE:
          if (!i_fifo_full)      w_next = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL:
          if (i_parity_done)        w_next = DECODE_ADDRESS;
          else if (i_low_pkt_valid) w_next = LOAD_PARITY;
          else                      w_next = LOAD_DATA;
        LOAD_PARITY:        w_next = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: w_next = i_fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY:
          if (i_fifo_empty[r_addr]) w_next = LOAD_FIRST_DATA;
          else if (w_timeout)       w_next = DECODE_ADDRESS;
        default:            w_next = DECODE_ADDRESS;
      endcase
    end
  end

  // Moore output decode from the registered state.
  always_comb begin
    o_detect_addr   = r_state == DECODE_ADDRESS;
    o_lfd_state     = r_state == LOAD_FIRST_DATA;
    o_ld_state      = r_state == LOAD_DATA;
    o_laf_state     = r_state == LOAD_AFTER_FULL;
    o_full_state    = r_state == FIFO_FULL_STATE;
    o_rst_int_reg   = r_state == CHECK_PARITY_ERROR;
    o_write_enb_reg = (r_state == LOAD_DATA) || (r_state == LOAD_PARITY) ||
                      (r_state == LOAD_AFTER_FULL);
    o_busy          = !((r_state == DECODE_ADDRESS) || (r_state == LOAD_DATA));
  end

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Self-checking bench for router_fsm_ctrl: directed scenarios plus random traffic,
// all compared cycle by cycle against a packet-level reference model.
module tb_router_fsm_ctrl;

  localparam int TO = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pv = 1'b0, full = 1'b0, pd = 1'b0, lpv = 1'b0;
  logic [1:0] din = 2'd0;
  logic [2:0] empty = 3'b111, srst = 3'b000;
  logic       detect, lfd, ld, laf, fst, rint, we, busy, drop;

  always #5 clk = ~clk;

  router_fsm_ctrl dut (
    .i_clk(clk), .i_rst(rst_n), .i_pkt_valid(pv), .i_din(din),
    .i_fifo_full(full), .i_fifo_empty(empty), .i_soft_reset(srst),
    .i_parity_done(pd), .i_low_pkt_valid(lpv),
    .o_detect_addr(detect), .o_lfd_state(lfd), .o_ld_state(ld),
    .o_laf_state(laf), .o_full_state(fst), .o_rst_int_reg(rint),
    .o_write_enb_reg(we), .o_busy(busy), .o_drop_pkt(drop)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---- reference model: packet phase, chosen port, wait length, drop strobe ----
  typedef enum int {P_IDLE, P_HDR, P_BODY, P_STALL, P_RESUME, P_PAR, P_CHK, P_WAIT} ph_t;
  ph_t        m_ph = P_IDLE;
  logic [1:0] m_addr = 2'd0;
  int         m_wait = 0;
  logic       m_drop = 1'b0;

  function automatic logic [8:0] m_out();
    logic [8:0] v;
    v[8] = m_ph == P_IDLE;
    v[7] = m_ph == P_HDR;
    v[6] = m_ph == P_BODY;
    v[5] = m_ph == P_RESUME;
    v[4] = m_ph == P_STALL;
    v[3] = m_ph == P_CHK;
    v[2] = m_ph inside {P_BODY, P_PAR, P_RESUME};
    v[1] = !(m_ph inside {P_IDLE, P_BODY});
    v[0] = m_drop;
    return v;
  endfunction

  function automatic logic [8:0] dut_out();
    return {detect, lfd, ld, laf, fst, rint, we, busy, drop};
  endfunction

  task automatic m_reset();
    m_ph = P_IDLE; m_addr = 2'd0; m_wait = 0; m_drop = 1'b0;
  endtask

  // One clock of the model using the current input values.
  task automatic m_step();
    ph_t        nph = m_ph;
    logic [1:0] na  = m_addr;
    int         nw  = 0;
    logic       nd  = 1'b0;
    if (m_ph == P_IDLE && pv && din < 2'd3) na = din;
    if (srst[m_addr]) nph = P_IDLE;
    else case (m_ph)
      P_IDLE:   if (pv && din < 2'd3) nph = empty[din] ? P_HDR : P_WAIT;
      P_HDR:    nph = P_BODY;
      P_BODY:   if (full) nph = P_STALL; else if (!pv) nph = P_PAR;
      P_STALL:  if (!full) nph = P_RESUME;
      P_RESUME: nph = pd ? P_IDLE : (lpv ? P_PAR : P_BODY);
      P_PAR:    nph = P_CHK;
      P_CHK:    nph = full ? P_STALL : P_IDLE;
      P_WAIT: begin
        if (empty[m_addr]) nph = P_HDR;
`ifdef ROUTER_FSM_TIMEOUT_EN
        else if (m_wait + 1 >= TO) begin nph = P_IDLE; nd = 1'b1; end
        else nw = m_wait + 1;
`endif
      end
      default:  nph = P_IDLE;
    endcase
    m_ph = nph; m_addr = na; m_wait = nw; m_drop = nd;
  endtask

  // Advance one clock and compare the full output vector mid-cycle.
  task automatic tick(input string tag);
    @(posedge clk);
    m_step();
    @(negedge clk);
    chk(tag, dut_out(), m_out());
  endtask

  task automatic drive(input logic v, input logic [1:0] d, input logic f,
                       input logic [2:0] e, input logic [2:0] s,
                       input logic p, input logic l);
    pv = v; din = d; full = f; empty = e; srst = s; pd = p; lpv = l;
  endtask

  initial begin
    int first_drop, n_drop;
    // reset state
    drive(0, 0, 0, 3'b111, 0, 0, 0);
    #12;
    chk("reset_outs", dut_out(), 9'b1_0000_0000);
    m_reset();
    @(negedge clk); rst_n = 1'b1;

    // 1: async reset mid-LOAD_DATA takes effect without a clock
    drive(1, 0, 0, 3'b111, 0, 0, 0);
    tick("t1_hdr"); tick("t1_ld"); tick("t1_ld2");
    chk("t1_in_ld", ld, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("t1_rst_detect", detect, 1'b1);
    chk("t1_rst_busy", busy, 1'b0);
    chk("t1_rst_we", we, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    chk("t1_rst_outs", dut_out(), m_out());

    // 2: clean packet to port 1, four payload beats
    drive(1, 2'b01, 0, 3'b111, 0, 0, 0);
    tick("t2_lfd");  chk("t2_lfd_bit", lfd, 1'b1);
    tick("t2_ld");   chk("t2_ld_bit", ld, 1'b1);
    for (int i = 0; i < 3; i++) tick("t2_body");
    pv = 0;
    tick("t2_par");  chk("t2_par_we", we, 1'b1);
    tick("t2_chk");  chk("t2_rint", rint, 1'b1);
    tick("t2_done"); chk("t2_detect", detect, 1'b1);

    // 3: invalid header address ignored
    drive(1, 2'b11, 0, 3'b111, 0, 0, 0);
    tick("t3_stay"); chk("t3_busy", busy, 1'b0);
    chk("t3_addr", dut.r_addr, 2'b01);

    // 4: full stall and resume paths
    drive(1, 0, 0, 3'b111, 0, 0, 0);
    tick("t4_lfd"); tick("t4_ld");
    full = 1;
    tick("t4_full"); chk("t4_full_bit", fst, 1'b1); chk("t4_busy", busy, 1'b1);
    full = 0; lpv = 1;
    tick("t4_laf");  chk("t4_laf_bit", laf, 1'b1);
    tick("t4_par");
    lpv = 0;
    tick("t4_chk");
    full = 1;
    tick("t4_full2");
    full = 0; pd = 1;
    tick("t4_laf2");
    tick("t4_done"); chk("t4_detect", detect, 1'b1);
    pd = 0;

    // 5: wait on busy port 2, soft reset of another port ignored, own port honoured
    drive(1, 2'b10, 0, 3'b011, 0, 0, 0);
    tick("t5_wait"); chk("t5_busy", busy, 1'b1);
    pv = 0; srst = 3'b001;
    tick("t5_ign");  chk("t5_no_detect", detect, 1'b0);
    srst = 3'b100;
    tick("t5_srst"); chk("t5_detect", detect, 1'b1);
    srst = 0;

`ifdef ROUTER_FSM_TIMEOUT_EN
    // 6: timeout in WAIT_TILL_EMPTY drops the packet once
    drive(1, 2'b00, 0, 3'b110, 0, 0, 0);
    tick("t6_wait");
    pv = 0;
    first_drop = 0; n_drop = 0;
    for (int k = 2; k <= 40; k++) begin
      tick("t6_run");
      if (drop) begin n_drop++; if (first_drop == 0) first_drop = k; end
    end
    chk("t6_drop_cycle", first_drop, 31);
    chk("t6_drop_count", n_drop, 1);
`else
    // 6 (feature off): WAIT never times out and drop stays 0
    drive(1, 2'b00, 0, 3'b110, 0, 0, 0);
    tick("t6_wait");
    pv = 0;
    n_drop = 0; first_drop = 0;
    for (int k = 0; k < 40; k++) begin
      tick("t6_hold");
      if (drop) n_drop++;
    end
    chk("t6_no_drop", n_drop, 0);
    chk("t6_still_busy", busy, 1'b1);
    srst = 3'b001;
    tick("t6_exit");
    srst = 0;
`endif

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      pv    = ($urandom_range(0, 3) != 0);
      din   = 2'($urandom_range(0, 3));
      full  = ($urandom_range(0, 3) == 0);
      empty = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      srst  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      pd    = ($urandom_range(0, 3) == 0);
      lpv   = ($urandom_range(0, 2) == 0);
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
